// File: rtl/tlb_victim_scan.sv
// ============================================================================
// Module      : tlb_victim_scan
// Description : TLB replacement-victim selector. Keeps saturating per-entry
//               access counters with periodic aging and scans a snapshot one
//               entry per cycle: invalid first, then non-global, then lowest
//               count. Optional per-entry locks via TLB_VICTIM_LOCK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tlb_victim_scan #(
    parameter int ENTRIES    = 8,
    parameter int ID_W       = $clog2(ENTRIES),
    parameter int CNT_W      = 12,
    parameter int AGE_PERIOD = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ENTRIES-1:0] valid_vec,
    input  logic [ENTRIES-1:0] global_vec,
    input  logic               hit,
    input  logic [ID_W-1:0]    hit_id,
    input  logic               fill,
    input  logic [ID_W-1:0]    fill_id,
    input  logic               flush,
    input  logic               req,
    output logic               busy,
    output logic               done,
    output logic [ID_W-1:0]    victim_id,
    output logic               victim_none
`ifdef TLB_VICTIM_LOCK_EN
    ,
    input  logic [ENTRIES-1:0] lock_vec
`endif
);

    localparam logic [1:0]      c_ST_IDLE  = 2'd0;
    localparam logic [1:0]      c_ST_SCAN  = 2'd1;
    localparam logic [1:0]      c_ST_DONE  = 2'd2;
    localparam int              c_TMR_W    = (AGE_PERIOD > 1) ? $clog2(AGE_PERIOD) : 1;
    localparam logic [31:0]     c_AGE_LAST = 32'(AGE_PERIOD - 1);
    localparam logic [ID_W-1:0] c_LAST_ID  = ID_W'(ENTRIES - 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic               w_load;
    logic               w_step;
    logic               w_repl;
    logic               w_age;
    logic [c_TMR_W-1:0] r_age_tmr;

    logic [CNT_W-1:0]   r_cnt     [ENTRIES];
    logic [CNT_W-1:0]   w_cnt_nxt [ENTRIES];
    logic [CNT_W-1:0]   r_sh_cnt  [ENTRIES];
    logic [ENTRIES-1:0] r_sh_valid;
    logic [ENTRIES-1:0] r_sh_global;
    logic [ID_W-1:0]    r_best;
    logic [ID_W-1:0]    r_idx;
    logic [ID_W-1:0]    r_victim_id;

    // ---------------- aging timer and live counters ----------------
    assign w_age = (AGE_PERIOD != 0) && (r_age_tmr == c_AGE_LAST[c_TMR_W-1:0]);

    always_ff @(posedge clk) begin
        if (rst || (AGE_PERIOD == 0) || w_age) begin
            r_age_tmr <= '0;
        end else begin
            r_age_tmr <= r_age_tmr + 1'b1;
        end
    end

    // Priority flush > fill > age > hit; a hit lands after the aging shift.
    always_comb begin
        for (int e = 0; e < ENTRIES; e++) begin
            w_cnt_nxt[e] = w_age ? (r_cnt[e] >> 1) : r_cnt[e];
            if (hit && (hit_id == ID_W'(e)) && (w_cnt_nxt[e] != c_CNT_MAX)) begin
                w_cnt_nxt[e] = w_cnt_nxt[e] + 1'b1;
            end
            if (flush || (fill && (fill_id == ID_W'(e)))) begin
                w_cnt_nxt[e] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int e = 0; e < ENTRIES; e++) begin
            r_cnt[e] <= rst ? '0 : w_cnt_nxt[e];
        end
    end

    // ---------------- scan FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (req) begin
                    w_load      = 1'b1;
                    w_state_nxt = c_ST_SCAN;
                end
            end
            c_ST_SCAN: begin
                busy   = 1'b1;
                w_step = 1'b1;
                if (r_idx == c_LAST_ID) begin
                    w_state_nxt = c_ST_DONE;
                end
            end
            c_ST_DONE: begin
                done        = 1'b1;
                w_state_nxt = c_ST_IDLE;
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

`ifdef TLB_VICTIM_LOCK_EN
    logic [ENTRIES-1:0] r_sh_lock;
    logic               r_best_none;
    logic               r_victim_none;
    assign victim_none = r_victim_none;
`else
    assign victim_none = 1'b0;
`endif

    // Candidate r_idx against current best; ties go to the candidate.
    always_comb begin
        if (r_sh_valid[r_idx] != r_sh_valid[r_best]) begin
            w_repl = !r_sh_valid[r_idx];
        end else if (r_sh_valid[r_idx] && (r_sh_global[r_idx] != r_sh_global[r_best])) begin
            w_repl = !r_sh_global[r_idx];
        end else begin
            w_repl = (r_sh_cnt[r_idx] <= r_sh_cnt[r_best]);
        end
`ifdef TLB_VICTIM_LOCK_EN
        if (r_sh_lock[r_idx]) begin
            w_repl = 1'b0;
        end else if (r_best_none) begin
            w_repl = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh_valid  <= '0;
            r_sh_global <= '0;
            r_best      <= '0;
            r_idx       <= '0;
            r_victim_id <= '0;
            for (int e = 0; e < ENTRIES; e++) begin
                r_sh_cnt[e] <= '0;
            end
`ifdef TLB_VICTIM_LOCK_EN
            r_sh_lock     <= '0;
            r_best_none   <= 1'b0;
            r_victim_none <= 1'b0;
`endif
        end else if (w_load) begin
            r_sh_valid  <= valid_vec;
            r_sh_global <= global_vec;
            r_best      <= '0;
            r_idx       <= ID_W'(1);
            for (int e = 0; e < ENTRIES; e++) begin
                r_sh_cnt[e] <= r_cnt[e];
            end
`ifdef TLB_VICTIM_LOCK_EN
            r_sh_lock   <= lock_vec;
            r_best_none <= lock_vec[0];
`endif
        end else if (w_step) begin
            r_idx <= r_idx + 1'b1;
            if (w_repl) begin
                r_best <= r_idx;
            end
            if (r_idx == c_LAST_ID) begin
                r_victim_id <= w_repl ? r_idx : r_best;
            end
`ifdef TLB_VICTIM_LOCK_EN
            if (w_repl) begin
                r_best_none <= 1'b0;
            end
            if (r_idx == c_LAST_ID) begin
                r_victim_none <= w_repl ? 1'b0 : r_best_none;
            end
`endif
        end
    end

    assign victim_id = r_victim_id;

endmodule

`default_nettype wire

// File: tb/tb_tlb_victim_scan.sv
// ============================================================================
// Module      : tb_tlb_victim_scan
// Description : Randomised and directed bench for tlb_victim_scan against a
//               key-based reference model (one aging and one non-aging DUT).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tlb_victim_scan;

    localparam int N    = 8;
    localparam int IW   = 3;
    localparam int CW   = 12;
    localparam int AP   = 16;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst, hit, fill, flush, req;
    logic [N-1:0]  valid_vec, global_vec, lock_vec;
    logic [IW-1:0] hit_id, fill_id;
    logic          busy_a, done_a, none_a, busy_n, done_n, none_n;
    logic [IW-1:0] vic_a, vic_n;

    always #5 clk = ~clk;

    tlb_victim_scan #(.ENTRIES(N), .ID_W(IW), .CNT_W(CW), .AGE_PERIOD(AP)) dut_a (
        .clk(clk), .rst(rst), .valid_vec(valid_vec), .global_vec(global_vec),
        .hit(hit), .hit_id(hit_id), .fill(fill), .fill_id(fill_id), .flush(flush),
        .req(req), .busy(busy_a), .done(done_a), .victim_id(vic_a), .victim_none(none_a)
`ifdef TLB_VICTIM_LOCK_EN
        , .lock_vec(lock_vec)
`endif
    );

    tlb_victim_scan #(.ENTRIES(N), .ID_W(IW), .CNT_W(CW), .AGE_PERIOD(0)) dut_n (
        .clk(clk), .rst(rst), .valid_vec(valid_vec), .global_vec(global_vec),
        .hit(hit), .hit_id(hit_id), .fill(fill), .fill_id(fill_id), .flush(flush),
        .req(req), .busy(busy_n), .done(done_n), .victim_id(vic_n), .victim_none(none_n)
`ifdef TLB_VICTIM_LOCK_EN
        , .lock_vec(lock_vec)
`endif
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int m_ca[N];
    int m_cn[N];
    int m_tmr, m_done_cyc, m_free, m_xa, m_xn, m_oa, m_on;
    bit m_pend, m_xnone, m_onone;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    // Victim = unlocked entry with the smallest (valid, valid&global, count) key, latest index on ties.
    function automatic int pick(input int c[N], input logic [N-1:0] v, input logic [N-1:0] g,
                                input logic [N-1:0] lk, output bit none);
        longint best_key = 0;
        int     best     = -1;
        for (int i = 0; i < N; i++) begin
            longint key = longint'(v[i]) * 2 * (MAXC + 1) + longint'(v[i] & g[i]) * (MAXC + 1) + c[i];
            if (!lk[i] && (best < 0 || key <= best_key)) begin
                best     = i;
                best_key = key;
            end
        end
        none = (best < 0);
        return none ? 0 : best;
    endfunction

    task automatic tick();
        bit age, nn, ed, eb;
        if (rst) begin
            for (int e = 0; e < N; e++) begin m_ca[e] = 0; m_cn[e] = 0; end
            m_tmr = 0; m_pend = 0; m_free = cyc + 1;
            m_oa = 0; m_on = 0; m_onone = 0;
        end else begin
            if (m_pend && cyc == m_done_cyc) m_pend = 0;
            if (!m_pend && req && cyc >= m_free) begin
                m_xa = pick(m_ca, valid_vec, global_vec, lock_vec, nn);
                m_xnone = nn;
                m_xn = pick(m_cn, valid_vec, global_vec, lock_vec, nn);
                m_pend = 1; m_done_cyc = cyc + N; m_free = cyc + N + 1;
            end
            age   = (m_tmr == AP - 1);
            m_tmr = age ? 0 : m_tmr + 1;
            for (int e = 0; e < N; e++) begin
                if (flush || (fill && fill_id == IW'(e))) begin
                    m_ca[e] = 0; m_cn[e] = 0;
                end else begin
                    if (age) m_ca[e] = m_ca[e] / 2;
                    if (hit && hit_id == IW'(e)) begin
                        m_ca[e] = (m_ca[e] + 1 > MAXC) ? MAXC : m_ca[e] + 1;
                        m_cn[e] = (m_cn[e] + 1 > MAXC) ? MAXC : m_cn[e] + 1;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        ed = m_pend && (cyc == m_done_cyc);
        eb = m_pend && (cyc < m_done_cyc);
        if (ed) begin m_oa = m_xa; m_on = m_xn; m_onone = m_xnone; end
        chk("busy_a", busy_a, eb);
        chk("busy_n", busy_n, eb);
        chk("done_a", done_a, ed);
        chk("done_n", done_n, ed);
        chk("victim_a", vic_a, m_oa);
        chk("victim_n", vic_n, m_on);
        chk("none_a", none_a, m_onone);
        chk("none_n", none_n, m_onone);
        for (int e = 0; e < N; e++) begin
            chk($sformatf("cnt_a[%0d]", e), dut_a.r_cnt[e], m_ca[e]);
            chk($sformatf("cnt_n[%0d]", e), dut_n.r_cnt[e], m_cn[e]);
        end
    endtask

    task automatic set_counts(input int c[N]);
        flush = 1'b1; tick(); flush = 1'b0;
        for (int e = 0; e < N; e++) begin
            for (int k = 0; k < c[e]; k++) begin
                hit = 1'b1; hit_id = IW'(e); tick();
            end
        end
        hit = 1'b0;
    endtask

    task automatic run_req();
        req = 1'b1; tick(); req = 1'b0;
        repeat (N + 1) tick();
    endtask

    initial begin
        int cnts[N];
        rst = 1'b1; hit = 1'b0; fill = 1'b0; flush = 1'b0; req = 1'b0;
        hit_id = '0; fill_id = '0; lock_vec = '0;
        valid_vec = '1; global_vec = '0;
        m_free = 0; m_pend = 0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // All valid, non-global: lowest count 3 on entries 1 and 3, later index wins.
        cnts = '{5, 3, 9, 3, 7, 8, 6, 4};
        set_counts(cnts);
        run_req();

        // One invalid entry beats lower counts elsewhere.
        cnts = '{2, 1, 3, 1, 2, 1, 9, 2};
        set_counts(cnts);
        valid_vec = 8'hBF;
        run_req();
        valid_vec = '1;

        // Only non-global entry wins despite holding the highest count.
        cnts = '{1, 1, 1, 1, 20, 1, 1, 1};
        set_counts(cnts);
        global_vec = 8'hEF;
        run_req();
        global_vec = '0;

        // Saturation on the non-aging instance, then fill beats a same-cycle hit.
        hit = 1'b1; hit_id = 3'd2;
        repeat (10000) tick();
        fill = 1'b1; fill_id = 3'd2;
        tick();
        fill = 1'b0; hit = 1'b0;
        tick();

        // Aging shift followed by a same-cycle hit: 6 -> 3 -> 4.
        while (m_tmr != 1) tick();
        flush = 1'b1; tick(); flush = 1'b0;
        hit = 1'b1; hit_id = 3'd1;
        repeat (6) tick();
        hit = 1'b0;
        while (m_tmr != AP - 1) tick();
        hit = 1'b1; tick(); hit = 1'b0;

        // req during scan ignored; reset mid-scan drops the result.
        req = 1'b1; tick(); req = 1'b0;
        tick();
        req = 1'b1; tick(); req = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
        repeat (N + 2) tick();

`ifdef TLB_VICTIM_LOCK_EN
        lock_vec = 8'hFF;
        run_req();
        lock_vec = 8'hFE;
        run_req();
        lock_vec = '0;
`endif

        repeat (3000) begin
            rst        = ($urandom_range(0, 299) == 0);
            flush      = ($urandom_range(0, 49) == 0);
            fill       = ($urandom_range(0, 7) == 0);
            fill_id    = IW'($urandom);
            hit        = ($urandom_range(0, 1) == 0);
            hit_id     = IW'($urandom);
            req        = ($urandom_range(0, 3) == 0);
            valid_vec  = ~(N'($urandom) & N'($urandom) & N'($urandom));
            global_vec = N'($urandom) & N'($urandom);
`ifdef TLB_VICTIM_LOCK_EN
            lock_vec   = ($urandom_range(0, 9) == 0) ? '1 : (N'($urandom) & N'($urandom));
`endif
            tick();
        end
        rst = 1'b0; hit = 1'b0; fill = 1'b0; flush = 1'b0; req = 1'b0;
        repeat (N + 2) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
